// File: rtl/stash_reply_arb.sv
// rtl/stash_reply_arb.sv - packet-locked 2:1 READ_REPLY arbiter with registered output
// Optional per-port packet counters: define STASH_REPLY_ARB_CNT_EN.
module stash_reply_arb #(
  parameter int DATA_W    = 256,
  parameter int KEEP_W    = 32,
  parameter int USER_W    = 128,
  parameter int PRIO_MODE = 0
) (
  input  logic              axis_aclk,
  input  logic              axis_resetn,

  input  logic [DATA_W-1:0] s0_axis_tdata,
  input  logic [KEEP_W-1:0] s0_axis_tkeep,
  input  logic [USER_W-1:0] s0_axis_tuser,
  input  logic              s0_axis_tvalid,
  output logic              s0_axis_tready,
  input  logic              s0_axis_tlast,

  input  logic [DATA_W-1:0] s1_axis_tdata,
  input  logic [KEEP_W-1:0] s1_axis_tkeep,
  input  logic [USER_W-1:0] s1_axis_tuser,
  input  logic              s1_axis_tvalid,
  output logic              s1_axis_tready,
  input  logic              s1_axis_tlast,

  output logic [DATA_W-1:0] m_axis_tdata,
  output logic [KEEP_W-1:0] m_axis_tkeep,
  output logic [USER_W-1:0] m_axis_tuser,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast,

  output logic [1:0]        o_grant
`ifdef STASH_REPLY_ARB_CNT_EN
  ,
  output logic [31:0]       o_pkt_cnt0,
  output logic [31:0]       o_pkt_cnt1
`endif
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  state_t     state;
  state_t     state_next;
  logic       last_grant;
  logic       last_next;
  logic       out_free;
  logic       acc0;
  logic       acc1;
  logic [1:0] grant_next;

  assign out_free   = ~m_axis_tvalid | m_axis_tready;
  assign acc0       = s0_axis_tvalid & s0_axis_tready;
  assign acc1       = s1_axis_tvalid & s1_axis_tready;
  assign grant_next = {state_next == GRANT1, state_next == GRANT0};

  // last_grant resets to s1 so that s0 wins the first tie
  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      o_grant    <= 2'b00;
    end else begin
      state      <= state_next;
      last_grant <= last_next;
      o_grant    <= grant_next;
    end
  end

  always_comb begin
    state_next = state;
    last_next  = last_grant;
    case (state)
      IDLE: begin
        if (s0_axis_tvalid && s1_axis_tvalid)
          state_next = ((PRIO_MODE == 1) || last_grant) ? GRANT0 : GRANT1;
        else if (s0_axis_tvalid)
          state_next = GRANT0;
        else if (s1_axis_tvalid)
          state_next = GRANT1;
      end
      GRANT0: begin
        if (acc0 && s0_axis_tlast) begin
          state_next = IDLE;
          last_next  = 1'b0;
        end
      end
      GRANT1: begin
        if (acc1 && s1_axis_tlast) begin
          state_next = IDLE;
          last_next  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    s0_axis_tready = 1'b0;
    s1_axis_tready = 1'b0;
    case (state)
      GRANT0:  s0_axis_tready = out_free;
      GRANT1:  s1_axis_tready = out_free;
      default: ;
    endcase
  end

  // Output slot: reload on accept, otherwise drain when downstream takes it
  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tuser  <= '0;
      m_axis_tlast  <= 1'b0;
    end else if (acc0) begin
      m_axis_tvalid <= 1'b1;
      m_axis_tdata  <= s0_axis_tdata;
      m_axis_tkeep  <= s0_axis_tkeep;
      m_axis_tuser  <= s0_axis_tuser;
      m_axis_tlast  <= s0_axis_tlast;
    end else if (acc1) begin
      m_axis_tvalid <= 1'b1;
      m_axis_tdata  <= s1_axis_tdata;
      m_axis_tkeep  <= s1_axis_tkeep;
      m_axis_tuser  <= s1_axis_tuser;
      m_axis_tlast  <= s1_axis_tlast;
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

`ifdef STASH_REPLY_ARB_CNT_EN
  logic [31:0] cnt0_q;
  logic [31:0] cnt1_q;

  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      cnt0_q <= 32'd0;
      cnt1_q <= 32'd0;
    end else begin
      if (acc0 && s0_axis_tlast)
        cnt0_q <= cnt0_q + 32'd1;
      if (acc1 && s1_axis_tlast)
        cnt1_q <= cnt1_q + 32'd1;
    end
  end

  assign o_pkt_cnt0 = cnt0_q;
  assign o_pkt_cnt1 = cnt1_q;
`endif

endmodule

// File: tb/tb_stash_reply_arb.sv
// tb/tb_stash_reply_arb.sv - self-checking bench for stash_reply_arb (PRIO_MODE 0 and 1 instances)
module tb_stash_reply_arb;
  localparam int DW = 256;
  localparam int KW = 32;
  localparam int UW = 128;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic [UW-1:0] u;
    logic          l;
  } beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic [DW-1:0] s0_tdata, s1_tdata;
  logic [KW-1:0] s0_tkeep, s1_tkeep;
  logic [UW-1:0] s0_tuser, s1_tuser;
  logic          s0_tvalid, s1_tvalid, s0_tlast, s1_tlast;
  logic          m_tready;

  logic          a_s0r, a_s1r, a_mv, a_ml, b_s0r, b_s1r, b_mv, b_ml;
  logic [DW-1:0] a_md, b_md;
  logic [KW-1:0] a_mk, b_mk;
  logic [UW-1:0] a_mu, b_mu;
  logic [1:0]    a_g, b_g;
`ifdef STASH_REPLY_ARB_CNT_EN
  logic [31:0]   a_c0, a_c1, b_c0, b_c1;
`endif

  stash_reply_arb #(.PRIO_MODE(0)) dut_a (
    .axis_aclk(clk), .axis_resetn(rst_n),
    .s0_axis_tdata(s0_tdata), .s0_axis_tkeep(s0_tkeep), .s0_axis_tuser(s0_tuser),
    .s0_axis_tvalid(s0_tvalid), .s0_axis_tready(a_s0r), .s0_axis_tlast(s0_tlast),
    .s1_axis_tdata(s1_tdata), .s1_axis_tkeep(s1_tkeep), .s1_axis_tuser(s1_tuser),
    .s1_axis_tvalid(s1_tvalid), .s1_axis_tready(a_s1r), .s1_axis_tlast(s1_tlast),
    .m_axis_tdata(a_md), .m_axis_tkeep(a_mk), .m_axis_tuser(a_mu),
    .m_axis_tvalid(a_mv), .m_axis_tready(m_tready), .m_axis_tlast(a_ml),
    .o_grant(a_g)
`ifdef STASH_REPLY_ARB_CNT_EN
    , .o_pkt_cnt0(a_c0), .o_pkt_cnt1(a_c1)
`endif
  );

  stash_reply_arb #(.PRIO_MODE(1)) dut_b (
    .axis_aclk(clk), .axis_resetn(rst_n),
    .s0_axis_tdata(s0_tdata), .s0_axis_tkeep(s0_tkeep), .s0_axis_tuser(s0_tuser),
    .s0_axis_tvalid(s0_tvalid), .s0_axis_tready(b_s0r), .s0_axis_tlast(s0_tlast),
    .s1_axis_tdata(s1_tdata), .s1_axis_tkeep(s1_tkeep), .s1_axis_tuser(s1_tuser),
    .s1_axis_tvalid(s1_tvalid), .s1_axis_tready(b_s1r), .s1_axis_tlast(s1_tlast),
    .m_axis_tdata(b_md), .m_axis_tkeep(b_mk), .m_axis_tuser(b_mu),
    .m_axis_tvalid(b_mv), .m_axis_tready(m_tready), .m_axis_tlast(b_ml),
    .o_grant(b_g)
`ifdef STASH_REPLY_ARB_CNT_EN
    , .o_pkt_cnt0(b_c0), .o_pkt_cnt1(b_c1)
`endif
  );

  // sel picks which instance the bench observes and whose tready drives the sources
  logic          sel;
  logic          o_s0r, o_s1r, o_mv, o_ml;
  logic [DW-1:0] o_md;
  logic [KW-1:0] o_mk;
  logic [UW-1:0] o_mu;
  logic [1:0]    o_g;
  assign o_s0r = sel ? b_s0r : a_s0r;
  assign o_s1r = sel ? b_s1r : a_s1r;
  assign o_mv  = sel ? b_mv  : a_mv;
  assign o_ml  = sel ? b_ml  : a_ml;
  assign o_md  = sel ? b_md  : a_md;
  assign o_mk  = sel ? b_mk  : a_mk;
  assign o_mu  = sel ? b_mu  : a_mu;
  assign o_g   = sel ? b_g   : a_g;

  int n_cmp = 0;
  int n_bad = 0;

  beat_t q0[$];
  beat_t q1[$];
  bit    pat[$];
  int    rate, mt_rate, cyc;
  bit    hs0, hs1;

  int    owner;
  bit    last_own;
  bit    mv;
  beat_t mslot;
  logic [31:0] mcnt0, mcnt1;

  logic [DW-1:0] log_d[$];
  int            log_c[$];
  logic [DW-1:0] exp_q[$];
  bit            saw_g2;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    check(tag, DW'(obs), DW'(exp));
  endtask

  task automatic push_pkt(input int src, input int len, input logic [7:0] base, input bit rnd);
    beat_t b;
    logic [7:0] v;
    for (int i = 0; i < len; i++) begin
      v   = base + 8'(i);
      b.d = rnd ? {8{$urandom}} : DW'(v);
      b.k = rnd ? KW'($urandom) : '1;
      b.u = rnd ? {4{$urandom}} : UW'(i);
      b.l = (i == len - 1);
      if (src == 0) q0.push_back(b); else q1.push_back(b);
    end
  endtask

  task automatic model_reset();
    owner = -1; last_own = 1'b1; mv = 1'b0; mslot = '0;
    mcnt0 = 32'd0; mcnt1 = 32'd0; hs0 = 1'b0; hs1 = 1'b0;
  endtask

  // Before the edge: compare against the reference and advance it by one clock
  task automatic pre_edge();
    bit free, e0, e1, a0, a1, was_idle;
    free = !mv || m_tready;
    e0 = (owner == 0) && free;
    e1 = (owner == 1) && free;
    check1("s0_tready", o_s0r, e0);
    check1("s1_tready", o_s1r, e1);
    check1("m_tvalid", o_mv, mv);
    if (mv) begin
      check("m_tdata", o_md, mslot.d);
      check("m_tkeep", DW'(o_mk), DW'(mslot.k));
      check("m_tuser", DW'(o_mu), DW'(mslot.u));
      check1("m_tlast", o_ml, mslot.l);
    end
    if (o_mv && m_tready) begin
      log_d.push_back(o_md);
      log_c.push_back(cyc);
    end
    hs0 = s0_tvalid && o_s0r;
    hs1 = s1_tvalid && o_s1r;
    a0 = s0_tvalid && e0 && q0.size() > 0;
    a1 = s1_tvalid && e1 && q1.size() > 0;
    was_idle = (owner < 0);
    if (a0 || a1) begin
      mslot = a0 ? q0[0] : q1[0];
      mv = 1'b1;
      if (mslot.l) begin
        last_own = a1;
        owner = -1;
        if (a0) mcnt0 = mcnt0 + 32'd1; else mcnt1 = mcnt1 + 32'd1;
      end
    end else if (m_tready) begin
      mv = 1'b0;
    end
    if (was_idle) begin
      if (s0_tvalid && s1_tvalid) owner = (sel || last_own) ? 0 : 1;
      else if (s0_tvalid) owner = 0;
      else if (s1_tvalid) owner = 1;
    end
  endtask

  task automatic drive();
    if (hs0) begin void'(q0.pop_front()); s0_tvalid = 1'b0; end
    if (hs1) begin void'(q1.pop_front()); s1_tvalid = 1'b0; end
    hs0 = 1'b0; hs1 = 1'b0;
    if (!s0_tvalid && q0.size() > 0 && $urandom_range(99) < rate) begin
      s0_tvalid = 1'b1;
      {s0_tdata, s0_tkeep, s0_tuser, s0_tlast} = q0[0];
    end
    if (!s1_tvalid && q1.size() > 0 && $urandom_range(99) < rate) begin
      s1_tvalid = 1'b1;
      {s1_tdata, s1_tkeep, s1_tuser, s1_tlast} = q1[0];
    end
    if (pat.size() > 0) m_tready = pat.pop_front();
    else m_tready = ($urandom_range(99) < mt_rate);
  endtask

  task automatic step();
    #4;
    pre_edge();
    @(posedge clk); #1;
    cyc++;
    check("o_grant", DW'(o_g), DW'({owner == 1, owner == 0}));
    if (o_g == 2'b10) saw_g2 = 1'b1;
    drive();
  endtask

  task automatic drain(input int limit);
    int n;
    n = 0;
    while ((q0.size() > 0 || q1.size() > 0 || mv || owner >= 0) && n < limit) begin
      step();
      n++;
    end
    if (n >= limit) begin
      n_cmp++; n_bad++;
      $error("FAIL drain_timeout observed=%0d cycles expected=<%0d", n, limit);
    end
  endtask

  task automatic clear_stim();
    q0.delete(); q1.delete(); pat.delete();
    s0_tvalid = 1'b0; s1_tvalid = 1'b0; s0_tlast = 1'b0; s1_tlast = 1'b0;
    s0_tdata = '0; s1_tdata = '0; s0_tkeep = '0; s1_tkeep = '0; s0_tuser = '0; s1_tuser = '0;
    log_d.delete(); log_c.delete(); exp_q.delete(); saw_g2 = 1'b0;
  endtask

  task automatic reset_all();
    rst_n = 1'b0;
    clear_stim();
    m_tready = 1'b1; rate = 100; mt_rate = 100;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check1("rst_m_tvalid", o_mv, 1'b0);
    check1("rst_m_tlast", o_ml, 1'b0);
    check("rst_m_tdata", o_md, '0);
    check("rst_o_grant", DW'(o_g), '0);
    check1("rst_s0_tready", o_s0r, 1'b0);
    check1("rst_s1_tready", o_s1r, 1'b0);
    rst_n = 1'b1;
  endtask

  task automatic check_log(input string tag);
    check({tag, "_count"}, DW'(log_d.size()), DW'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < log_d.size(); i++)
      check({tag, "_beat"}, log_d[i], exp_q[i]);
  endtask

  initial begin
    sel = 1'b0; cyc = 0;
    s0_tvalid = 1'b0; s1_tvalid = 1'b0; m_tready = 1'b1;

    // single source, 3 beats
    reset_all();
    push_pkt(0, 3, 8'hA1, 1'b0);
    drive();
    drain(40);
    exp_q = '{DW'(8'hA1), DW'(8'hA2), DW'(8'hA3)};
    check_log("single");
    if (log_c.size() == 3) begin
      check("single_gap1", DW'(log_c[1] - log_c[0]), DW'(1));
      check("single_gap2", DW'(log_c[2] - log_c[1]), DW'(1));
    end

    // contention, round-robin
    reset_all();
    for (int p = 0; p < 2; p++) begin
      push_pkt(0, 2, 8'h10, 1'b0);
      push_pkt(1, 2, 8'h20, 1'b0);
    end
    drive();
    drain(60);
    exp_q = '{DW'(8'h10), DW'(8'h11), DW'(8'h20), DW'(8'h21),
              DW'(8'h10), DW'(8'h11), DW'(8'h20), DW'(8'h21)};
    check_log("rr");
    if (log_c.size() == 8) begin
      check("rr_inpkt_gap", DW'(log_c[1] - log_c[0]), DW'(1));
      check("rr_pkt_gap", DW'(log_c[2] - log_c[1]), DW'(2));
    end

    // fixed priority instance
    sel = 1'b1;
    reset_all();
    for (int p = 0; p < 3; p++) push_pkt(0, 2, 8'h10, 1'b0);
    for (int p = 0; p < 2; p++) push_pkt(1, 2, 8'h20, 1'b0);
    drive();
    drain(80);
    exp_q = '{DW'(8'h10), DW'(8'h11), DW'(8'h10), DW'(8'h11), DW'(8'h10), DW'(8'h11),
              DW'(8'h20), DW'(8'h21), DW'(8'h20), DW'(8'h21)};
    check_log("prio");
    sel = 1'b0;

    // backpressure on a 4-beat s1 packet
    reset_all();
    push_pkt(1, 4, 8'hC1, 1'b0);
    pat = '{1, 0, 0, 1, 1, 0, 1};
    drive();
    drain(60);
    exp_q = '{DW'(8'hC1), DW'(8'hC2), DW'(8'hC3), DW'(8'hC4)};
    check_log("bp");

    // reset while the 2nd beat of a 3-beat s0 packet is on the bus
    reset_all();
    push_pkt(0, 3, 8'hB1, 1'b0);
    drive();
    for (int n = 0; n < 20 && q0.size() > 2; n++) step();
    check("mid_beat2_present", DW'(s0_tvalid ? s0_tdata : '0), DW'(8'hB2));
    #2 rst_n = 1'b0;
    #1;
    check1("mid_rst_m_tvalid", o_mv, 1'b0);
    check1("mid_rst_s0_tready", o_s0r, 1'b0);
    check1("mid_rst_s1_tready", o_s1r, 1'b0);
    check("mid_rst_o_grant", DW'(o_g), '0);
    clear_stim();
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    push_pkt(1, 1, 8'h55, 1'b0);
    drive();
    drain(30);
    exp_q = '{DW'(8'h55)};
    check_log("post_rst");
    check1("post_rst_grant10", saw_g2, 1'b1);

    // randomized traffic on both instances
    for (int s = 0; s < 2; s++) begin
      int total;
      sel = s[0];
      reset_all();
      total = 0;
      for (int p = 0; p < 12; p++) begin
        int l0, l1;
        l0 = $urandom_range(1, 4);
        l1 = $urandom_range(1, 4);
        push_pkt(0, l0, 8'h00, 1'b1);
        push_pkt(1, l1, 8'h00, 1'b1);
        total += l0 + l1;
      end
      rate = $urandom_range(40, 100);
      mt_rate = 75;
      drive();
      drain(3000);
      check("rand_beats", DW'(log_d.size()), DW'(total));
      check("rand_cnt0", DW'(mcnt0), DW'(12));
      check("rand_cnt1", DW'(mcnt1), DW'(12));
    end
    sel = 1'b0;

`ifdef STASH_REPLY_ARB_CNT_EN
    reset_all();
    for (int p = 0; p < 5; p++) push_pkt(0, $urandom_range(1, 3), 8'h30, 1'b0);
    for (int p = 0; p < 3; p++) push_pkt(1, $urandom_range(1, 3), 8'h40, 1'b0);
    drive();
    drain(200);
    check("cnt0_five", DW'(a_c0), DW'(5));
    check("cnt1_three", DW'(a_c1), DW'(3));
    force dut_a.cnt0_q = 32'hFFFF_FFFF;
    #1 release dut_a.cnt0_q;
    check("cnt0_preload", DW'(a_c0), DW'(32'hFFFF_FFFF));
    push_pkt(0, 2, 8'h60, 1'b0);
    drive();
    drain(40);
    check("cnt0_wrap", DW'(a_c0), DW'(0));
    check("cnt1_hold", DW'(a_c1), DW'(3));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
